// File: rtl/result_checker.sv
// Self-check unit: scores one processor result per cycle against a loadable
// expected-value table, counting passes/failures and capturing the first mismatch.
module result_checker #(
    parameter  int WIDTH       = 32,
    parameter  int NUM_CHECKS  = 29,
    parameter  int START_DELAY = 0,
    localparam int IDX_W       = $clog2(NUM_CHECKS),
    localparam int CNT_W       = $clog2(NUM_CHECKS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] Result,
    input  logic             exp_we,
    input  logic [IDX_W-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_value,
    output logic             fail_seen
);

    localparam int DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [IDX_W:0]   NCHK     = (IDX_W + 1)'(NUM_CHECKS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic [WIDTH-1:0] ffv_q, ffv_d;
    logic             seen_q, seen_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             idle_like;
    logic             match;

    logic [WIDTH-1:0] exp_mem [NUM_CHECKS];

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign match     = (Result == exp_mem[idx_q]);

    // Table is deliberately not reset; writes only land outside a run.
    always_ff @(posedge clk) begin
        if (!reset && exp_we && idle_like && ({1'b0, exp_addr} < NCHK))
            exp_mem[exp_addr] <= exp_data;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        seen_d  = seen_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d  = '0;
                    pass_d = '0;
                    fail_d = '0;
                    ffi_d  = '0;
                    ffv_d  = '0;
                    seen_d = 1'b0;
                    dly_d  = DLY_W'(START_DELAY);
                    state_d = (START_DELAY == 0) ? S_CHECK : S_WAIT;
                end
            end
            S_WAIT: begin
                dly_d = dly_q - DLY_W'(1);
                if (dly_q <= DLY_W'(1))
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (result_valid) begin
                    if (match) begin
                        pass_d = pass_q + CNT_W'(1);
                    end else begin
                        fail_d = fail_q + CNT_W'(1);
                        if (!seen_q) begin
                            ffi_d  = idx_q;
                            ffv_d  = Result;
                            seen_d = 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX)
                        state_d = S_DONE;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dly_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffi_q   <= '0;
            ffv_q   <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign all_pass         = done_q && (fail_q == '0);
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_value = ffv_q;
    assign fail_seen        = seen_q;

endmodule
